// File: rtl/loader_pkg.sv
// loader_pkg: shared widths, nibble constants and FSM encoding for the instruction loader
package loader_pkg;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int NIB = 4;
  localparam int NIB_W = 4;
  localparam int DIGIT_MS = 3;
  typedef enum logic {COLLECT = 1'b0, WRITE = 1'b1} loader_state_t;
endpackage

// File: rtl/nibble_assembler.sv
// nibble_assembler: builds a word MS nibble first; done fires on the final nibble
module nibble_assembler
  import loader_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [NIB_W-1:0] nibble_i,
  output logic [DW-1:0]    shadow_o,
  output logic [DW-1:0]    word_o,
  output logic [1:0]       digit_o,
  output logic             done_o
);
  logic [DW-1:0] shadow_q, shadow_d;
  logic [1:0] digit_q, digit_d;
  always_comb begin
    word_o = shadow_q;
    word_o[{digit_q, 2'b00} +: NIB_W] = nibble_i;
  end
  assign done_o = load_i && digit_q == 2'd0;
  assign shadow_d = (clear_i || done_o) ? '0 : load_i ? word_o : shadow_q;
  assign digit_d = (clear_i || done_o) ? 2'(DIGIT_MS) : load_i ? digit_q - 2'd1 : digit_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      digit_q  <= 2'(DIGIT_MS);
    end else begin
      shadow_q <= shadow_d;
      digit_q  <= digit_d;
    end
  end
  assign shadow_o = shadow_q;
  assign digit_o = digit_q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: keypad nibble entry writing 16-bit words to instruction RAM via valid/ready
module instr_loader
  import loader_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             strobe_i,
  input  logic [NIB_W-1:0] nibble_i,
  input  logic             set_addr_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             wr_ready_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [DW-1:0]    wr_data_o,
  output logic [DW-1:0]    shadow_o,
  output logic [1:0]       digit_o,
  output logic             busy_o,
  output logic             wrapped_o
);
  loader_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, word;
  logic wr_en_q, wr_en_d, wrapped_q, wrapped_d;
  logic take, load, clear, done, accept;
  assign take = state_q == COLLECT && strobe_i;
  assign load = take && !set_addr_i;
  assign clear = take && set_addr_i;
  assign accept = state_q == WRITE && wr_ready_i;
  nibble_assembler u_asm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .clear_i (clear),
    .nibble_i(nibble_i),
    .shadow_o(shadow_o),
    .word_o  (word),
    .digit_o (digit_o),
    .done_o  (done)
  );
  always_comb begin
    state_d   = done ? WRITE : accept ? COLLECT : state_q;
    wr_en_d   = done || (wr_en_q && !accept);
    addr_d    = clear ? addr_i : accept ? addr_q + 1'b1 : addr_q;
    data_d    = done ? word : data_q;
    wrapped_d = wrapped_q || (accept && &addr_q);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= COLLECT;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wrapped_q <= wrapped_d;
    end
  end
  assign wr_en_o = wr_en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign wrapped_o = wrapped_q;
  assign busy_o = state_q == WRITE;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed steps with a write scoreboard drained by a handshake monitor
module tb_instr_loader;
  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;
  logic clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, set_addr = 1'b0, wr_ready = 1'b1;
  logic [3:0] nibble = '0;
  logic [6:0] addr_in = '0;
  logic wr_en, busy, wrapped;
  logic [6:0] wr_addr;
  logic [15:0] wr_data, shadow;
  logic [1:0] digit;
  int passed = 0, total = 0;
  wr_t sb[$];
  always #5 clk = ~clk;
  instr_loader dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .strobe_i  (strobe),
    .nibble_i  (nibble),
    .set_addr_i(set_addr),
    .addr_i    (addr_in),
    .wr_ready_i(wr_ready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .shadow_o  (shadow),
    .digit_o   (digit),
    .busy_o    (busy),
    .wrapped_o (wrapped)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic key(input logic [3:0] n);
    strobe = 1'b1;
    nibble = n;
    cyc();
    strobe = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      if (sb.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'hFFFF);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_addr", 32'(wr_addr), 32'(e.a));
        chk("sb_data", 32'(wr_data), 32'(e.d));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc();
    cyc();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_shadow", 32'(shadow), 0);
    chk("rst_digit", 32'(digit), 3);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    rst_n = 1'b1;
    key(4'hA);
    chk("sh_A000", 32'(shadow), 32'hA000);
    chk("digit_2", 32'(digit), 2);
    key(4'h1);
    chk("sh_A100", 32'(shadow), 32'hA100);
    key(4'hF);
    chk("sh_A1F0", 32'(shadow), 32'hA1F0);
    sb.push_back('{7'h00, 16'hA1F3});
    key(4'h3);
    chk("w0_wr_en", 32'(wr_en), 1);
    chk("w0_busy", 32'(busy), 1);
    chk("w0_addr", 32'(wr_addr), 0);
    chk("w0_data", 32'(wr_data), 32'hA1F3);
    chk("w0_shadow_clr", 32'(shadow), 0);
    chk("w0_digit", 32'(digit), 3);
    cyc();
    chk("w0_pulse_end", 32'(wr_en), 0);
    chk("w0_busy_end", 32'(busy), 0);
    chk("w0_addr_inc", 32'(wr_addr), 1);
    key(4'h1);
    key(4'h2);
    key(4'h3);
    wr_ready = 1'b0;
    sb.push_back('{7'h01, 16'h1234});
    key(4'h4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_wr_en", 32'(wr_en), 1);
      chk("stall_addr", 32'(wr_addr), 1);
      chk("stall_data", 32'(wr_data), 32'h1234);
      chk("stall_shadow", 32'(shadow), 0);
      chk("stall_digit", 32'(digit), 3);
      strobe = 1'b1;
      nibble = 4'hF;
      set_addr = i[0];
      addr_in = 7'h55;
      cyc();
    end
    strobe = 1'b0;
    set_addr = 1'b0;
    chk("stall_hold6", 32'(wr_en), 1);
    chk("stall_addr6", 32'(wr_addr), 1);
    chk("stall_shadow6", 32'(shadow), 0);
    wr_ready = 1'b1;
    cyc();
    chk("stall_done", 32'(wr_en), 0);
    chk("stall_addr_inc", 32'(wr_addr), 2);
    key(4'hB);
    key(4'hE);
    chk("partial_BE00", 32'(shadow), 32'hBE00);
    chk("partial_digit", 32'(digit), 1);
    set_addr = 1'b1;
    addr_in = 7'h7F;
    key(4'h0);
    set_addr = 1'b0;
    chk("seta_shadow", 32'(shadow), 0);
    chk("seta_digit", 32'(digit), 3);
    chk("seta_addr", 32'(wr_addr), 32'h7F);
    chk("seta_no_write", 32'(wr_en), 0);
    key(4'hB);
    key(4'hE);
    key(4'hE);
    sb.push_back('{7'h7F, 16'hBEEF});
    key(4'hF);
    chk("beef_addr", 32'(wr_addr), 32'h7F);
    chk("beef_data", 32'(wr_data), 32'hBEEF);
    chk("beef_wrapped_pre", 32'(wrapped), 0);
    cyc();
    chk("wrap_addr", 32'(wr_addr), 0);
    chk("wrap_flag", 32'(wrapped), 1);
    key(4'h0);
    key(4'h0);
    key(4'h0);
    sb.push_back('{7'h00, 16'h0001});
    key(4'h1);
    cyc();
    chk("sticky_wrapped", 32'(wrapped), 1);
    chk("after_wrap_addr", 32'(wr_addr), 1);
    wr_ready = 1'b0;
    key(4'h5);
    key(4'h6);
    key(4'h7);
    key(4'h8);
    chk("pre_rst_wr_en", 32'(wr_en), 1);
    chk("pre_rst_data", 32'(wr_data), 32'h5678);
    rst_n = 1'b0;
    cyc();
    chk("wrst_wr_en", 32'(wr_en), 0);
    chk("wrst_busy", 32'(busy), 0);
    chk("wrst_addr", 32'(wr_addr), 0);
    chk("wrst_data", 32'(wr_data), 0);
    chk("wrst_wrapped", 32'(wrapped), 0);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    cyc();
    cyc();
    chk("wrst_no_write", 32'(wr_en), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
